// File: rtl/writeback_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : writeback_arbiter_pkg
// Purpose  : Core-wide constants shared by the writeback path and register file.
// Revision : 1.0 - initial release
// ============================================================================
package writeback_arbiter_pkg;

  localparam int NUM_WB_PORTS = 4;
  localparam int REG_IDX_W    = 4;
  localparam int REG_DATA_W   = 8;

endpackage
`default_nettype wire

// File: rtl/wb_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : wb_rr_pick
// Purpose  : Combinational rotation scan: grants, write-port assignment, next pointer.
// Revision : 1.0 - initial release
// ============================================================================
module wb_rr_pick
  import writeback_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 5,
  parameter int DES_W   = REG_IDX_W,
  parameter int DATA_W  = REG_DATA_W,
  parameter int PTR_W   = 3
) (
  input  logic [NUM_REQ-1:0]             req_vld,
  input  logic [NUM_REQ*DES_W-1:0]       req_des,
  input  logic [NUM_REQ*DATA_W-1:0]      req_data,
  input  logic [PTR_W-1:0]               ptr,
  output logic [NUM_REQ-1:0]             grant,
  output logic [NUM_WB_PORTS-1:0]        port_vld,
  output logic [NUM_WB_PORTS*DES_W-1:0]  port_des,
  output logic [NUM_WB_PORTS*DATA_W-1:0] port_data,
  output logic [PTR_W-1:0]               ptr_nxt
);

  localparam int PORT_IDX_W = $clog2(NUM_WB_PORTS);

  logic [DES_W-1:0]    des_arr   [NUM_REQ];
  logic [DATA_W-1:0]   data_arr  [NUM_REQ];
  logic [DES_W-1:0]    pdes_arr  [NUM_WB_PORTS];
  logic [DATA_W-1:0]   pdata_arr [NUM_WB_PORTS];
  logic [PORT_IDX_W:0] n_used;
  logic [PTR_W:0]      scan_sum;
  logic [PTR_W-1:0]    idx;
  logic                blocked;
  logic                clash;

  generate
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign des_arr[i]  = req_des[i*DES_W +: DES_W];
      assign data_arr[i] = req_data[i*DATA_W +: DATA_W];
    end
    for (genvar i = 0; i < NUM_WB_PORTS; i++) begin : g_pack
      assign port_des[i*DES_W +: DES_W]    = pdes_arr[i];
      assign port_data[i*DATA_W +: DATA_W] = pdata_arr[i];
    end
  endgenerate

  always_comb begin
    grant    = '0;
    port_vld = '0;
    ptr_nxt  = ptr;
    n_used   = '0;
    scan_sum = '0;
    idx      = '0;
    blocked  = 1'b0;
    clash    = 1'b0;
    for (int j = 0; j < NUM_WB_PORTS; j++) begin
      pdes_arr[j]  = '0;
      pdata_arr[j] = '0;
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_sum = {1'b0, ptr} + (PTR_W+1)'(k);
      if (scan_sum >= (PTR_W+1)'(NUM_REQ)) begin
        scan_sum = scan_sum - (PTR_W+1)'(NUM_REQ);
      end
      idx   = scan_sum[PTR_W-1:0];
      clash = 1'b0;
      for (int j = 0; j < NUM_WB_PORTS; j++) begin
        if (port_vld[j] && (pdes_arr[j] == des_arr[idx])) begin
          clash = 1'b1;
        end
      end
      if (req_vld[idx]) begin
        // reg0 is hard-wired zero: accept and drop without using a port
        if (des_arr[idx] == '0) begin
          grant[idx] = 1'b1;
        end else if (!clash && (n_used < (PORT_IDX_W+1)'(NUM_WB_PORTS))) begin
          grant[idx]                         = 1'b1;
          port_vld[n_used[PORT_IDX_W-1:0]]   = 1'b1;
          pdes_arr[n_used[PORT_IDX_W-1:0]]   = des_arr[idx];
          pdata_arr[n_used[PORT_IDX_W-1:0]]  = data_arr[idx];
          n_used                             = n_used + 1'b1;
        end else if (!blocked) begin
          blocked = 1'b1;
          ptr_nxt = idx;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : writeback_arbiter
// Purpose  : Round-robin merge of result producers onto four register-file write ports.
// Revision : 1.0 - initial release
// ============================================================================
module writeback_arbiter
  import writeback_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = 5,
  parameter int des            = REG_IDX_W,
  parameter int register_width = REG_DATA_W
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_REQ-1:0]                req_vld,
  input  logic [NUM_REQ*des-1:0]            req_des,
  input  logic [NUM_REQ*register_width-1:0] req_data,
  output logic [NUM_REQ-1:0]                req_rdy,
  output logic                              back_1_vld,
  output logic [des-1:0]                    back_1_des,
  output logic [register_width-1:0]         back_1_data,
  output logic                              back_2_vld,
  output logic [des-1:0]                    back_2_des,
  output logic [register_width-1:0]         back_2_data,
  output logic                              back_3_vld,
  output logic [des-1:0]                    back_3_des,
  output logic [register_width-1:0]         back_3_data,
  output logic                              back_4_vld,
  output logic [des-1:0]                    back_4_des,
  output logic [register_width-1:0]         back_4_data
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]                     grant;
  logic [PTR_W-1:0]                       ptr_nxt;
  logic [NUM_WB_PORTS-1:0]                port_vld;
  logic [NUM_WB_PORTS*des-1:0]            port_des;
  logic [NUM_WB_PORTS*register_width-1:0] port_data;

  logic [PTR_W-1:0]                       ptr_q, ptr_d;
  logic [NUM_WB_PORTS-1:0]                back_vld_q, back_vld_d;
  logic [NUM_WB_PORTS*des-1:0]            back_des_q, back_des_d;
  logic [NUM_WB_PORTS*register_width-1:0] back_data_q, back_data_d;

  wb_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .DES_W   (des),
    .DATA_W  (register_width),
    .PTR_W   (PTR_W)
  ) u_pick (
    .req_vld   (req_vld),
    .req_des   (req_des),
    .req_data  (req_data),
    .ptr       (ptr_q),
    .grant     (grant),
    .port_vld  (port_vld),
    .port_des  (port_des),
    .port_data (port_data),
    .ptr_nxt   (ptr_nxt)
  );

  // No handshake may complete while reset holds the datapath
  assign req_rdy = rst ? '0 : grant;

  always_comb begin
    ptr_d       = ptr_nxt;
    back_vld_d  = port_vld;
    back_des_d  = port_des;
    back_data_d = port_data;
    if (rst) begin
      ptr_d       = '0;
      back_vld_d  = '0;
      back_des_d  = '0;
      back_data_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    ptr_q       <= ptr_d;
    back_vld_q  <= back_vld_d;
    back_des_q  <= back_des_d;
    back_data_q <= back_data_d;
  end

  assign back_1_vld  = back_vld_q[0];
  assign back_2_vld  = back_vld_q[1];
  assign back_3_vld  = back_vld_q[2];
  assign back_4_vld  = back_vld_q[3];
  assign back_1_des  = back_des_q[0*des +: des];
  assign back_2_des  = back_des_q[1*des +: des];
  assign back_3_des  = back_des_q[2*des +: des];
  assign back_4_des  = back_des_q[3*des +: des];
  assign back_1_data = back_data_q[0*register_width +: register_width];
  assign back_2_data = back_data_q[1*register_width +: register_width];
  assign back_3_data = back_data_q[2*register_width +: register_width];
  assign back_4_data = back_data_q[3*register_width +: register_width];

endmodule
`default_nettype wire

// File: doc/writeback_arbiter.md
WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 5, number of result producers (4 ALU channels + load unit).
REQ-002 SHALL have parameter des, default 4, register-index width.
REQ-003 SHALL have parameter register_width, default 8, data width.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on posedge clk.
REQ-005 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-006 SHALL have port req_vld  input  NUM_REQ  per-producer result valid.
REQ-007 SHALL have port req_des  input  NUM_REQ x des  per-producer destination register.
REQ-008 SHALL have port req_data  input  NUM_REQ x register_width  per-producer result data.
REQ-009 SHALL have port req_rdy  output  NUM_REQ  per-producer grant, combinational from current inputs and pointer.
REQ-010 SHALL have ports back_1..4_vld  output  1 each  register-file write-port valid, registered.
REQ-011 SHALL have ports back_1..4_des  output  des each  register-file write-port destination, registered.
REQ-012 SHALL have ports back_1..4_data  output  register_width each  register-file write-port data, registered.

Function
REQ-013 SHALL treat a transfer as req_vld[i] && req_rdy[i] on a rising clk; producer holds vld/des/data stable until transfer.
REQ-014 SHALL scan producers in rotation order starting at the pointer ptr (0..NUM_REQ-1), wrapping modulo NUM_REQ.
REQ-015 SHALL grant in scan order each valid producer with des != 0 while fewer than 4 ports are assigned and no earlier grant this cycle has the same des.
REQ-016 SHALL grant any valid producer with des == 0 unconditionally, consume no port, and emit no write (reg0 is hard zero).
REQ-017 SHALL not grant a valid producer blocked by port exhaustion or same-des conflict; it keeps its request.
REQ-018 SHALL assign granted nonzero-des requests to back_1, back_2, back_3, back_4 in scan order; unused ports get vld=0, des=0, data=0.
REQ-019 SHALL register port contents: write visible on back_n_* exactly 1 cycle after the transfer cycle.
REQ-020 SHALL guarantee at most one back_n_vld per destination per cycle.
REQ-021 SHALL update ptr each cycle to the first valid-but-ungranted producer in scan order; if none, ptr holds.
REQ-022 SHALL grant any continuously valid request within NUM_REQ cycles (no starvation).
REQ-023 SHALL deassert all req_rdy when no req_vld is set; req_rdy[i] SHALL be 0 whenever req_vld[i] is 0.
REQ-024 SHALL produce all-zero back ports the cycle after an idle cycle.

Reset
REQ-025 SHALL, while rst is high at a clk edge, set ptr=0 and all back_n_vld/des/data=0.
REQ-026 SHALL force req_rdy=0 while rst is high; requests presented during reset are not transferred.
REQ-027 SHALL discard an in-flight registered write when rst asserts mid-operation (back_n_vld=0 next cycle).

Structure
REQ-028 SHALL take NUM_WB_PORTS (4), register-index width, and register_width from the shared core package, also used by the register file.
REQ-029 SHALL instantiate one sub-module wb_rr_pick performing the combinational rotation scan (grants, port assignment, next ptr).
REQ-030 SHALL contain all sequential state (ptr, back-port registers) in writeback_arbiter itself.

Verification
REQ-031 SHALL cover: 4 producers valid, des 1,2,3,4, data 0x11..0x44, ptr=0 -> all rdy=1; next cycle back_1..4 = (1,0x11)..(4,0x44).
REQ-032 SHALL cover: all 5 valid, des 1..5, ptr=0 -> producer 4 rdy=0, ptr becomes 4; producer 4 held -> granted next cycle, on back_1 the cycle after.
REQ-033 SHALL cover: producers 0 and 1 both des 7 (data 0xA0, 0xB0), ptr=0 -> only 0 granted, back_1=(7,0xA0); producer 1 granted next cycle, back_1=(7,0xB0).
REQ-034 SHALL cover: producer 2 des 0 data 0xFF with producers 0,1,3,4 des 1,2,3,4 -> all 5 rdy=1, no write to reg0, back_1..4 = des 1,2,3,4.
REQ-035 SHALL cover: all 5 valid, producer 0 repeatedly reissuing des 5 and producer 1 holding des 5, for 10 cycles -> producer 1 granted within 5 cycles.
REQ-036 SHALL cover: rst asserted the cycle after a 4-write transfer -> back_n_vld=0, ptr=0, req_rdy=0 during reset.
